// File: rtl/uart_word_tx.sv
// ---------------------------------------------------------------------------
// uart_word_tx
//   Serial UART transmitter for 32-bit display words. Each accepted word is
//   sent as four 8N1 bytes, most significant byte first, with no gap between
//   bytes. One idle-high clock separates consecutive words when send is held.
//
// Ports
//   clk    in   1   system clock, rising edge
//   rst    in   1   synchronous reset, active-high
//   tx_en  in   1   1 = accept send requests; a frame in flight always completes
//   send   in   1   level-sensitive request, sampled every cycle while idle
//   data   in   32  word to transmit, latched only on acceptance
//   tx     out  1   serial line, idle high, registered
//   busy   out  1   high while a word is in flight, registered
//   done   out  1   one-cycle pulse after the final stop bit, registered
// ---------------------------------------------------------------------------
module uart_word_tx #(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 9600
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tx_en,
    input  logic        send,
    input  logic [31:0] data,
    output logic        tx,
    output logic        busy,
    output logic        done
);

    localparam int BIT_CLKS = CLK_FREQ / BAUD;
    localparam int CNT_W    = (BIT_CLKS > 2) ? $clog2(BIT_CLKS) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BIT_CLKS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t           state, state_next;
    logic [CNT_W-1:0] baud_cnt, baud_cnt_next;
    logic [2:0]       bit_idx, bit_idx_next;
    logic [1:0]       byte_idx, byte_idx_next;
    logic [31:0]      shift_reg, shift_reg_next;
    logic             tx_next, busy_next, done_next;
    logic             bit_end;

    assign bit_end = (baud_cnt == CNT_MAX);

    // Outputs are computed one cycle ahead and registered, so tx/busy/done
    // change exactly on the clock edge at which the state changes.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        state_next     = state;
        baud_cnt_next  = (bit_end || state == IDLE) ? '0 : baud_cnt + CNT_W'(1);
        bit_idx_next   = bit_idx;
        byte_idx_next  = byte_idx;
        shift_reg_next = shift_reg;
        tx_next        = tx;
        busy_next      = busy;
        done_next      = 1'b0;

        case (state)
            IDLE: begin
                if (tx_en && send) begin
                    state_next     = START;
                    shift_reg_next = data;
                    bit_idx_next   = '0;
                    byte_idx_next  = '0;
                    tx_next        = 1'b0;
                    busy_next      = 1'b1;
                end
            end
            START: begin
                if (bit_end) begin
                    state_next   = DATA;
                    bit_idx_next = '0;
                    // ~byte_idx selects data[31:24] for byte 0 ... data[7:0] for byte 3.
                    tx_next      = shift_reg[{~byte_idx, 3'd0}];
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_idx == 3'd7) begin
                        state_next = STOP;
                        tx_next    = 1'b1;
                    end else begin
                        bit_idx_next = bit_idx + 3'd1;
                        tx_next      = shift_reg[{~byte_idx, bit_idx + 3'd1}];
                    end
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (byte_idx == 2'd3) begin
                        state_next = IDLE;
                        busy_next  = 1'b0;
                        done_next  = 1'b1;
                        tx_next    = 1'b1;
                    end else begin
                        state_next    = START;
                        byte_idx_next = byte_idx + 2'd1;
                        tx_next       = 1'b0;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values regardless of statement order.
        if (rst) begin
            state     <= IDLE;
            baud_cnt  <= '0;
            bit_idx   <= '0;
            byte_idx  <= '0;
            shift_reg <= '0;
            tx        <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_next;
            baud_cnt  <= baud_cnt_next;
            bit_idx   <= bit_idx_next;
            byte_idx  <= byte_idx_next;
            shift_reg <= shift_reg_next;
            tx        <= tx_next;
            busy      <= busy_next;
            done      <= done_next;
        end
    end

endmodule

// File: tb/tb_uart_word_tx.sv
// ---------------------------------------------------------------------------
// tb_uart_word_tx
//   Directed self-checking bench for uart_word_tx with CLK_FREQ=80, BAUD=10
//   (8 clocks per bit, 320 clocks per word). Inputs change and outputs are
//   sampled on the falling clock edge; cycle 0 is the rising edge at which a
//   send is accepted.
// ---------------------------------------------------------------------------
module tb_uart_word_tx;

    localparam int BIT_CLKS  = 8;
    localparam int WORD_CLKS = 40 * BIT_CLKS;

    logic        clk = 1'b0;
    logic        rst;
    logic        tx_en;
    logic        send;
    logic [31:0] data;
    logic        tx, busy, done;

    int tests_run = 0;
    int tests_failed = 0;

    uart_word_tx #(
        .CLK_FREQ (80),
        .BAUD     (10)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .tx_en (tx_en),
        .send  (send),
        .data  (data),
        .tx    (tx),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    // Expected line level in cycle k (1..WORD_CLKS) of a frame carrying w.
    function automatic logic exp_tx(input logic [31:0] w, input int k);
        int bit_pos;
        int byte_num;
        int slot;
        bit_pos  = (k - 1) / BIT_CLKS;
        byte_num = bit_pos / 10;
        slot     = bit_pos % 10;
        if (slot == 0) return 1'b0;
        if (slot == 9) return 1'b1;
        return w[8 * (3 - byte_num) + slot - 1];
    endfunction

    // Called at the falling edge of cycle 1. Checks the whole word and the
    // done cycle, returning at the falling edge of cycle WORD_CLKS+1.
    // If inject_at > 0, a send of 32'hFFFF_FFFF is raised for one cycle there.
    task automatic expect_frame(input logic [31:0] w, input string tag, input int inject_at);
        for (int k = 1; k <= WORD_CLKS; k++) begin
            if (inject_at > 0 && k == inject_at) begin
                send = 1'b1;
                data = 32'hFFFF_FFFF;
            end else if (inject_at > 0 && k == inject_at + 1) begin
                send = 1'b0;
            end
            check({tag, "_tx"}, {31'd0, tx}, {31'd0, exp_tx(w, k)});
            check({tag, "_busy"}, {31'd0, busy}, 32'd1);
            check({tag, "_done_early"}, {31'd0, done}, 32'd0);
            @(negedge clk);
        end
        check({tag, "_done"}, {31'd0, done}, 32'd1);
        check({tag, "_busy_end"}, {31'd0, busy}, 32'd0);
        check({tag, "_tx_end"}, {31'd0, tx}, 32'd1);
    endtask

    task automatic expect_idle(input string tag, input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            check({tag, "_tx"}, {31'd0, tx}, 32'd1);
            check({tag, "_busy"}, {31'd0, busy}, 32'd0);
            check({tag, "_done"}, {31'd0, done}, 32'd0);
        end
    endtask

    // Raises send for one accepting edge; returns at the falling edge of cycle 1.
    task automatic pulse_send(input logic [31:0] w);
        send = 1'b1;
        data = w;
        @(negedge clk);
        send = 1'b0;
    endtask

    initial begin
        rst   = 1'b1;
        tx_en = 1'b1;
        send  = 1'b1;
        data  = 32'h1234_5678;

        // 1: reset held two cycles with send asserted
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check("rst_tx", {31'd0, tx}, 32'd1);
            check("rst_busy", {31'd0, busy}, 32'd0);
            check("rst_done", {31'd0, done}, 32'd0);
        end
        rst  = 1'b0;
        send = 1'b0;
        expect_idle("post_rst", 4);

        // 2: single word
        pulse_send(32'h6801_1033);
        expect_frame(32'h6801_1033, "single", 0);
        expect_idle("single_after", 10);

        // 3: send while busy is ignored
        pulse_send(32'h6801_1033);
        expect_frame(32'h6801_1033, "busy_send", 100);
        expect_idle("busy_after", 40);

        // 4: reset mid-frame, then a clean frame
        pulse_send(32'hC3A5_0F81);
        for (int k = 1; k <= 50; k++) begin
            check("pre_rst_tx", {31'd0, tx}, {31'd0, exp_tx(32'hC3A5_0F81, k)});
            if (k == 50) rst = 1'b1;
            @(negedge clk);
        end
        rst = 1'b0;
        check("midrst_tx", {31'd0, tx}, 32'd1);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_done", {31'd0, done}, 32'd0);
        expect_idle("midrst_idle", 20);
        pulse_send(32'h9E37_79B9);
        expect_frame(32'h9E37_79B9, "after_rst", 0);
        expect_idle("after_rst_idle", 4);

        // 5: back-to-back words with send held
        send = 1'b1;
        data = 32'hA5A5_0000;
        @(negedge clk);
        expect_frame(32'hA5A5_0000, "b2b_first", 0);
        @(negedge clk);
        expect_frame(32'hA5A5_0000, "b2b_second", 0);
        send = 1'b0;
        expect_idle("b2b_after", 10);

        // 6: tx_en low blocks sends, raising it starts a frame next cycle
        tx_en = 1'b0;
        send  = 1'b1;
        data  = 32'h0F0F_F0F0;
        expect_idle("tx_en_low", 500);
        tx_en = 1'b1;
        @(negedge clk);
        send = 1'b0;
        expect_frame(32'h0F0F_F0F0, "tx_en_high", 0);
        expect_idle("final", 4);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
